// File: rtl/mul_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// mul_acc_pkg
// Shared definitions for the multiply-accumulate back end:
//   accState_e - job sequencing states (IDLE, ACC, OUT_LO, OUT_HI)
//   accMax()   - largest value an accumulator of a given width can hold
//   HI_SAT_BIT - bit position of the saturation flag in the high result byte
// ---------------------------------------------------------------------------
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    OUT_LO = 2'd2,
    OUT_HI = 2'd3
  } accState_e;

  // The saturation flag rides in the MSB of the high byte so the consumer
  // can tell a clamped result from a genuine all-ones value.
  localparam int HI_SAT_BIT = 7;

  // All-ones value for an accumulator of width accW.
  function automatic int accMax(input int accW);
    return (1 << accW) - 1;
  endfunction

endpackage

// File: rtl/mul_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational saturating adder: sum = min(a + b, 2^ACC_W-1).
// Ports:
//   a        in  ACC_W  current accumulator value
//   b        in  8      unsigned product, zero-extended before the add
//   sum      out ACC_W  clamped sum
//   overflow out 1      true sum did not fit in ACC_W bits
// ---------------------------------------------------------------------------
module sat_add
  import mul_acc_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(accMax(ACC_W));

  logic [ACC_W:0] wideSum;

  // One extra bit of headroom catches the carry out; since b is at most 255
  // and ACC_W >= 9, a single add can overflow by less than one full range,
  // so the carry bit alone decides saturation.
  always_comb begin
    wideSum  = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
    overflow = wideSum[ACC_W];
    sum      = overflow ? ACC_MAX : wideSum[ACC_W-1:0];
  end

endmodule

// File: rtl/mul_accumulator.sv
// ---------------------------------------------------------------------------
// mul_accumulator
// Sums a programmed number of 8-bit products into a saturating accumulator
// and returns the result as two bytes (low, then {sat, 0.., acc[ACC_W-1:8]}).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ena              global enable; 0 freezes all state and both handshakes
//   start, len       begin a job of len products (sampled in IDLE only)
//   prod, prod_valid, prod_ready   product input handshake
//   res_byte, res_valid, res_ready result output handshake
//   busy             high whenever a job is in progress
//   done             one-cycle pulse after the high byte is accepted
// ---------------------------------------------------------------------------
module mul_accumulator
  import mul_acc_pkg::*;
#(
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 5,
  parameter int PROD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [7:0]        res_byte,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done
);

  accState_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;

  logic [ACC_W-1:0] addSum;
  logic             addOvf;
  logic [7:0]       hiByte;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a        (acc_q),
    .b        (prod),
    .sum      (addSum),
    .overflow (addOvf)
  );

  // State register. Reset is asynchronous so a job abandoned mid-way drops
  // straight back to IDLE with nothing left to emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Everything holds while ena is low; done_d defaults to
  // 0 so the done pulse cannot stretch across a freeze.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            rem_d   = len;
            state_d = (len == '0) ? OUT_LO : ACC;
          end
        end
        ACC: begin
          // prod_ready is always high here when ena is, so a transfer is
          // simply prod_valid.
          if (prod_valid) begin
            acc_d = addSum;
            sat_d = sat_q | addOvf;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = OUT_LO;
          end
        end
        OUT_LO: begin
          if (res_ready) state_d = OUT_HI;
        end
        OUT_HI: begin
          if (res_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // High byte packs the sticky saturation flag above the upper accumulator
  // bits, with zero fill in between for narrower accumulators.
  always_comb begin
    hiByte                 = '0;
    hiByte[ACC_W-9:0]      = acc_q[ACC_W-1:8];
    hiByte[HI_SAT_BIT]     = sat_q;
  end

  // Output decode from registered state. ena is the one exception: both
  // handshakes must drop in the very cycle the block is frozen, otherwise a
  // neighbour would see a transfer that the block does not take.
  always_comb begin
    prod_ready = ena && (state_q == ACC);
    res_valid  = ena && ((state_q == OUT_LO) || (state_q == OUT_HI));
    busy       = (state_q != IDLE);
    done       = done_q && ena;
    case (state_q)
      OUT_LO:  res_byte = acc_q[7:0];
      OUT_HI:  res_byte = hiByte;
      default: res_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mul_accumulator
// Self-checking bench for mul_accumulator (default parameters). Expected
// result bytes come from a plain arithmetic model: clamp the sum of the
// job's products to 4095 and flag whether clamping happened.
// ---------------------------------------------------------------------------
module tb_mul_accumulator;

  localparam int ACC_MAX_TB = 4095;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [4:0] len;
  logic [7:0] prod;
  logic       prod_valid;
  logic       prod_ready;
  logic [7:0] res_byte;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int prodQ[$];

  mul_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .res_byte   (res_byte),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .done       (done)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream of the bounded loops wedges.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one complete job from IDLE using the products in prodQ.
  // gaps randomly drops prod_valid, pokeStart sprinkles ignored start pulses,
  // holdLo stalls the low byte, freezeAt (>=0) drops ena for 4 cycles once
  // that many products have been taken.
  task automatic applyStimulus(input int n, input bit gaps, input bit pokeStart,
                               input int holdLo, input int freezeAt);
    int  total;
    int  expVal;
    bit  expSat;
    int  idx;
    int  guard;
    bit  froze;
    bit  tr;
    total = 0;
    foreach (prodQ[i]) total += prodQ[i];
    expSat = (total > ACC_MAX_TB);
    expVal = expSat ? ACC_MAX_TB : total;

    start = 1'b1;
    len   = 5'(n);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    checkOutput("prodReadyAfterStart", 32'(prod_ready), 32'(n != 0));

    idx = 0;
    guard = 0;
    froze = 1'b0;
    while (idx < n && guard < 400) begin
      if (!froze && idx == freezeAt) begin
        froze = 1'b1;
        ena = 1'b0;
        prod_valid = 1'b1;
        prod = 8'd50;
        repeat (4) begin
          #1;
          checkOutput("freezeReady", 32'(prod_ready), 32'd0);
          checkOutput("freezeBusy", 32'(busy), 32'd1);
          @(posedge clk); #1;
        end
        ena = 1'b1;
      end
      prod_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      prod = 8'(prodQ[idx]);
      if (pokeStart) begin
        start = 1'($urandom_range(0, 1));
        len = 5'($urandom_range(0, 31));
      end
      #1;
      tr = prod_valid && prod_ready;
      @(posedge clk); #1;
      if (tr) idx++;
      guard++;
    end
    prod_valid = 1'b0;
    start = 1'b0;
    if (guard >= 400) checkOutput("prodTimeout", 32'(idx), 32'(n));

    checkOutput("loValid", 32'(res_valid), 32'd1);
    checkOutput("loByte", 32'(res_byte), 32'(expVal & 255));
    checkOutput("loProdReady", 32'(prod_ready), 32'd0);
    repeat (holdLo) begin
      @(posedge clk); #1;
      checkOutput("loHoldValid", 32'(res_valid), 32'd1);
      checkOutput("loHoldByte", 32'(res_byte), 32'(expVal & 255));
    end

    res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hiValid", 32'(res_valid), 32'd1);
    checkOutput("hiByte", 32'(res_byte), 32'((int'(expSat) << 7) | (expVal >> 8)));
    checkOutput("doneEarly", 32'(done), 32'd0);

    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("donePulse", 32'(done), 32'd1);
    checkOutput("busyWithDone", 32'(busy), 32'd0);
    checkOutput("idleValid", 32'(res_valid), 32'd0);

    @(posedge clk); #1;
    checkOutput("doneCleared", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    ena = 1'b1;
    start = 1'b0;
    len = '0;
    prod = '0;
    prod_valid = 1'b0;
    res_ready = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rstProdReady", 32'(prod_ready), 32'd0);
    checkOutput("rstResValid", 32'(res_valid), 32'd0);
    checkOutput("rstResByte", 32'(res_byte), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic job");
    prodQ = '{15, 225, 100};
    applyStimulus(3, 1'b0, 1'b0, 0, -1);

    $display("[TB] zero length");
    prodQ = {};
    applyStimulus(0, 1'b0, 1'b0, 0, -1);

    $display("[TB] saturation");
    prodQ = {};
    repeat (20) prodQ.push_back(225);
    applyStimulus(20, 1'b0, 1'b0, 0, -1);

    $display("[TB] gaps, stray start and result backpressure");
    prodQ = '{15, 225, 100};
    applyStimulus(3, 1'b1, 1'b1, 5, -1);

    $display("[TB] enable freeze mid-job");
    prodQ = '{15, 225, 100};
    applyStimulus(3, 1'b0, 1'b0, 0, 1);

    $display("[TB] maximum length, all-ones products");
    prodQ = {};
    repeat (31) prodQ.push_back(255);
    applyStimulus(31, 1'b1, 1'b0, 1, -1);

    $display("[TB] reset mid-job");
    start = 1'b1;
    len = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 8'd10;
    @(posedge clk); #1;
    prod = 8'd20;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    checkOutput("preRstReady", 32'(prod_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", 32'(prod_ready), 32'd0);
    checkOutput("midRstValid", 32'(res_valid), 32'd0);
    checkOutput("midRstByte", 32'(res_byte), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstValid", 32'(res_valid), 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    prodQ = '{7};
    applyStimulus(1, 1'b0, 1'b0, 0, -1);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(0, 31);
      prodQ = {};
      for (int k = 0; k < n; k++) prodQ.push_back($urandom_range(0, 255));
      applyStimulus(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), (n > 2) ? $urandom_range(0, n - 1) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
